// File: rtl/i2c_passthru_pkg.sv
// rtl/i2c_passthru_pkg.sv - shared states, constants and direction rule for the I2C pass-through bit sequencer
package i2c_passthru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BIT  = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    localparam logic [3:0] ACK_IDX      = 4'd8;
    localparam logic [3:0] RW_IDX       = 4'd7;
    localparam logic [7:0] BYTE_CNT_MAX = 8'd255;

    // 1 = bit travels toward the master
    function automatic logic dir_to_mst(input logic [3:0] bit_idx,
                                        input logic [7:0] byte_cnt,
                                        input logic       rw,
                                        input logic       nack);
        logic is_ack;
        is_ack = (bit_idx == ACK_IDX);
        if (nack)
            return 1'b0;
        else if ((byte_cnt != 8'd0) && rw)
            return !is_ack;
        else
            return is_ack;
    endfunction

endpackage

// File: rtl/i2c_passthru_bitseq_if.sv
// rtl/i2c_passthru_bitseq_if.sv - bit-sequencer handshake bundle between bus monitor, transmitter and sequencer
interface i2c_passthru_bitseq_if;
    logic       i_f_ref;
    logic       i_start_det;
    logic       i_stop_det;
    logic       i_bit_valid;
    logic       i_bit_val;
    logic       i_tx_done;
    logic       i_tx_violation;
    logic       o_start_tx;
    logic       o_tx_is_to_mst;
    logic [3:0] o_bit_idx;
    logic       o_rw;
    logic       o_nack;
    logic       o_busy;
    logic       o_error;

    modport slave (
        input  i_f_ref, i_start_det, i_stop_det, i_bit_valid, i_bit_val,
               i_tx_done, i_tx_violation,
        output o_start_tx, o_tx_is_to_mst, o_bit_idx, o_rw, o_nack, o_busy, o_error
    );

    modport master (
        output i_f_ref, i_start_det, i_stop_det, i_bit_valid, i_bit_val,
               i_tx_done, i_tx_violation,
        input  o_start_tx, o_tx_is_to_mst, o_bit_idx, o_rw, o_nack, o_busy, o_error
    );
endinterface

// File: rtl/i2c_passthru_fref_timer.sv
// rtl/i2c_passthru_fref_timer.sv - down-counter clocked by rising edges of a slow reference
module i2c_passthru_fref_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             fref,
    output logic             tc
);
    logic             fref_q;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fref_q <= 1'b0;
            cnt    <= '0;
        end else begin
            fref_q <= fref;
            if (load)
                cnt <= value;
            else if (fref && !fref_q && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/i2c_passthru_bitseq.sv
// rtl/i2c_passthru_bitseq.sv - per-bit sequencer driving the pass-through transmitter
module i2c_passthru_bitseq
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_TIMEOUT = 255,
    parameter int WIDTH_TIMEOUT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    i2c_passthru_bitseq_if.slave  bus
);
    state_t     state, state_d;
    logic [3:0] bit_idx;
    logic [7:0] byte_cnt;
    logic       rw, nack, error;
    logic       restart, advance, stop_clr, in_xfer, fault;
    logic       tmr_load, tmr_tc;

    // Faults outrank STOP, which outranks START, which outranks normal progress
    always_comb begin
        state_d  = state;
        restart  = 1'b0;
        advance  = 1'b0;
        stop_clr = 1'b0;
        in_xfer  = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
        fault    = bus.i_tx_violation || (in_xfer && (tmr_tc || bus.i_start_det));
        if (state != ST_ERROR) begin
            if (fault) begin
                state_d = ST_ERROR;
            end else if (bus.i_stop_det) begin
                state_d  = ST_IDLE;
                stop_clr = 1'b1;
            end else if (bus.i_start_det) begin
                state_d = ST_WAIT_BIT;
                restart = 1'b1;
            end else begin
                case (state)
                    ST_WAIT_BIT:  if (bus.i_bit_valid && bus.i_tx_done) state_d = ST_LAUNCH;
                    ST_LAUNCH:    state_d = ST_WAIT_BUSY;
                    ST_WAIT_BUSY: if (!bus.i_tx_done) state_d = ST_WAIT_DONE;
                    ST_WAIT_DONE: if (bus.i_tx_done) begin
                        state_d = ST_WAIT_BIT;
                        advance = 1'b1;
                    end
                    default:      state_d = state;
                endcase
            end
        end
    end

    assign tmr_load = (restart || (state_d != state)) &&
                      ((state_d == ST_WAIT_BIT) || (state_d == ST_WAIT_BUSY) ||
                       (state_d == ST_WAIT_DONE));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            bit_idx  <= 4'd0;
            byte_cnt <= 8'd0;
            rw       <= 1'b0;
            nack     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_d;
            if (state_d == ST_ERROR)
                error <= 1'b1;
            if (restart) begin
                bit_idx  <= 4'd0;
                byte_cnt <= 8'd0;
                rw       <= 1'b0;
                nack     <= 1'b0;
            end else if (stop_clr) begin
                bit_idx <= 4'd0;
            end else if (advance) begin
                if (bit_idx == ACK_IDX) begin
                    nack    <= bus.i_bit_val;
                    bit_idx <= 4'd0;
                    if (byte_cnt != BYTE_CNT_MAX)
                        byte_cnt <= byte_cnt + 8'd1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
                if ((bit_idx == RW_IDX) && (byte_cnt == 8'd0))
                    rw <= bus.i_bit_val;
            end
        end
    end

    i2c_passthru_fref_timer #(
        .WIDTH (WIDTH_TIMEOUT)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .load   (tmr_load),
        .value  (WIDTH_TIMEOUT'(F_REF_TIMEOUT)),
        .fref   (bus.i_f_ref),
        .tc     (tmr_tc)
    );

    assign bus.o_start_tx     = (state == ST_LAUNCH);
    assign bus.o_tx_is_to_mst = dir_to_mst(bit_idx, byte_cnt, rw, nack);
    assign bus.o_bit_idx      = bit_idx;
    assign bus.o_rw           = rw;
    assign bus.o_nack         = nack;
    assign bus.o_busy         = (state != ST_IDLE) && (state != ST_ERROR);
    assign bus.o_error        = error;
endmodule

// File: tb/tb_i2c_passthru_bitseq.sv
// tb/tb_i2c_passthru_bitseq.sv - randomized self-checking bench for the I2C pass-through bit sequencer
module tb_i2c_passthru_bitseq;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_passthru_bitseq_if bus ();

    i2c_passthru_bitseq #(
        .F_REF_TIMEOUT (4),
        .WIDTH_TIMEOUT (3)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses;
    logic seq[$];

    // Reference view of the transfer: byte number, bit-in-byte, latched R/W and NACK
    int   m_idx, m_byte;
    logic m_rw, m_nack;

    function automatic logic ref_to_mst(input int byte_no, input int idx,
                                        input logic rw_l, input logic nack_l);
        if (nack_l) return 1'b0;
        if (byte_no > 0 && rw_l) return (idx < 8);
        return (idx == 8);
    endfunction

    task automatic drive_idle();
        bus.i_f_ref        = 1'b0;
        bus.i_start_det    = 1'b0;
        bus.i_stop_det     = 1'b0;
        bus.i_bit_valid    = 1'b0;
        bus.i_bit_val      = 1'b0;
        bus.i_tx_done      = 1'b1;
        bus.i_tx_violation = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        bus.i_start_det = 1'b1;
        @(negedge clk);
        bus.i_start_det = 1'b0;
        m_idx = 0; m_byte = 0; m_rw = 1'b0; m_nack = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.i_stop_det = 1'b1;
        @(negedge clk);
        bus.i_stop_det = 1'b0;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) seq.push_back(b[i]);
    endtask

    // Present a bit and wait (bounded) for the launch; returns what was seen at launch
    task automatic wait_launch(output logic got, output logic [3:0] idx, output logic dir);
        got = 1'b0; idx = 4'd0; dir = 1'b0;
        bus.i_bit_valid = 1'b1;
        bus.i_tx_done   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_start_tx) begin
                got = 1'b1; idx = bus.o_bit_idx; dir = bus.o_tx_is_to_mst;
                pulses++;
                break;
            end
        end
    endtask

    task automatic finish_bit();
        @(negedge clk);
        if (bus.o_start_tx) pulses++;
        bus.i_tx_done = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_bit_valid = 1'b0;
    endtask

    task automatic run_seq(input string tag);
        logic got, dir, v;
        logic [3:0] idx;
        while (seq.size() > 0) begin
            v = seq.pop_front();
            bus.i_bit_val = v;
            wait_launch(got, idx, dir);
            n_cmp++;
            if (!got) begin
                n_fail++;
                $display("FAIL %s launch: no o_start_tx within 20 cycles (byte %0d bit %0d)", tag, m_byte, m_idx);
            end
            n_cmp++;
            if (idx !== 4'(m_idx)) begin
                n_fail++;
                $display("FAIL %s bit_idx: got %0d expected %0d", tag, idx, m_idx);
            end
            n_cmp++;
            if (dir !== ref_to_mst(m_byte, m_idx, m_rw, m_nack)) begin
                n_fail++;
                $display("FAIL %s dir byte %0d bit %0d: got %0b expected %0b", tag, m_byte, m_idx,
                         dir, ref_to_mst(m_byte, m_idx, m_rw, m_nack));
            end
            finish_bit();
            if (m_byte == 0 && m_idx == 7) m_rw = v;
            if (m_idx == 8) begin
                m_nack = v; m_idx = 0; m_byte++;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.o_busy, bus.o_start_tx, bus.o_rw, bus.o_nack, bus.o_error, bus.o_tx_is_to_mst} !== 6'b0 ||
            bus.o_bit_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset outputs: busy/start/rw/nack/err/dir=%b idx=%0d expected all 0",
                     {bus.o_busy, bus.o_start_tx, bus.o_rw, bus.o_nack, bus.o_error, bus.o_tx_is_to_mst},
                     bus.o_bit_idx);
        end
    endtask

    task automatic test_write();
        pulses = 0;
        pulse_start();
        add_byte(8'h50); seq.push_back(1'b0);
        add_byte(8'($urandom)); seq.push_back(1'b0);
        run_seq("write");
        pulse_stop();
        n_cmp++;
        if (pulses !== 18) begin n_fail++; $display("FAIL write pulses: got %0d expected 18", pulses); end
        n_cmp++;
        if (bus.o_rw !== 1'b0 || bus.o_nack !== 1'b0) begin
            n_fail++; $display("FAIL write rw/nack: got %b%b expected 00", bus.o_rw, bus.o_nack);
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_bit_idx !== 4'd0 || bus.o_error !== 1'b0) begin
            n_fail++; $display("FAIL write idle: busy %b idx %0d err %b expected 0 0 0",
                               bus.o_busy, bus.o_bit_idx, bus.o_error);
        end
    endtask

    task automatic test_read();
        pulse_start();
        add_byte(8'h51); seq.push_back(1'b0);
        add_byte(8'($urandom)); seq.push_back(1'b1);
        for (int i = 0; i < 3; i++) seq.push_back(1'($urandom));
        run_seq("read");
        n_cmp++;
        if (bus.o_rw !== 1'b1 || bus.o_nack !== 1'b1) begin
            n_fail++; $display("FAIL read rw/nack: got %b%b expected 11", bus.o_rw, bus.o_nack);
        end
        pulse_stop();
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL read busy after stop: got %b expected 0", bus.o_busy); end
    endtask

    task automatic test_restart();
        pulse_start();
        add_byte(8'h51); seq.push_back(1'b0);
        for (int i = 0; i < 5; i++) seq.push_back(1'($urandom));
        run_seq("restart");
        n_cmp++;
        if (bus.o_bit_idx !== 4'd5 || bus.o_rw !== 1'b1) begin
            n_fail++; $display("FAIL restart pre: idx %0d rw %b expected 5 1", bus.o_bit_idx, bus.o_rw);
        end
        pulse_start();
        n_cmp++;
        if (bus.o_bit_idx !== 4'd0 || bus.o_rw !== 1'b0 || bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL restart post: idx %0d rw %b err %b busy %b expected 0 0 0 1",
                               bus.o_bit_idx, bus.o_rw, bus.o_error, bus.o_busy);
        end
        pulse_stop();
    endtask

    task automatic test_timeout();
        logic got, dir;
        logic [3:0] idx;
        pulse_start();
        wait_launch(got, idx, dir);
        bus.i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        for (int e = 1; e <= 4; e++) begin
            bus.i_f_ref = 1'b1;
            @(negedge clk);
            bus.i_f_ref = 1'b0;
            @(negedge clk);
            if (e == 3) begin
                n_cmp++;
                if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
                    n_fail++; $display("FAIL timeout early: err %b busy %b after 3 edges expected 0 1",
                                       bus.o_error, bus.o_busy);
                end
            end
        end
        n_cmp++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout expiry: err %b busy %b expected 1 0", bus.o_error, bus.o_busy);
        end
        bus.i_tx_done = 1'b1;
        pulse_stop();
        pulse_start();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_start_tx !== 1'b0) begin
            n_fail++; $display("FAIL error sticky: err %b busy %b start %b expected 1 0 0",
                               bus.o_error, bus.o_busy, bus.o_start_tx);
        end
        do_reset();
        n_cmp++;
        if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL error cleared by reset: got %b expected 0", bus.o_error); end
    endtask

    task automatic test_fault_priority();
        logic got, dir;
        logic [3:0] idx;
        pulse_start();
        wait_launch(got, idx, dir);
        bus.i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_tx_violation = 1'b1;
        bus.i_stop_det     = 1'b1;
        @(negedge clk);
        bus.i_tx_violation = 1'b0;
        bus.i_stop_det     = 1'b0;
        n_cmp++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL violation+stop: err %b busy %b expected 1 0", bus.o_error, bus.o_busy);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic got, dir;
        logic [3:0] idx;
        int extra;
        pulse_start();
        wait_launch(got, idx, dir);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_start_tx, bus.o_rw, bus.o_nack, bus.o_error} !== 5'b0 || bus.o_bit_idx !== 4'd0) begin
            n_fail++; $display("FAIL reset mid-bit: busy/start/rw/nack/err=%b idx %0d expected all 0",
                               {bus.o_busy, bus.o_start_tx, bus.o_rw, bus.o_nack, bus.o_error}, bus.o_bit_idx);
        end
        rstn  = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_start_tx) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin n_fail++; $display("FAIL no launch after reset: got %0d pulses expected 0", extra); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] addr;
        logic       last_ack;
        int         nbytes;
        for (int t = 0; t < 4; t++) begin
            addr     = 8'($urandom);
            nbytes   = $urandom_range(1, 2);
            last_ack = 1'b0;
            pulse_start();
            add_byte(addr); seq.push_back(1'b0);
            for (int b = 0; b < nbytes; b++) begin
                add_byte(8'($urandom));
                last_ack = 1'($urandom);
                seq.push_back(last_ack);
            end
            run_seq("b2b");
            n_cmp++;
            if (bus.o_rw !== addr[0] || bus.o_nack !== last_ack) begin
                n_fail++; $display("FAIL b2b rw/nack: got %b%b expected %b%b", bus.o_rw, bus.o_nack, addr[0], last_ack);
            end
            pulse_stop();
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write();
        test_read();
        test_restart();
        test_timeout();
        test_fault_priority();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
